// File: rtl/change_dispenser.sv
// Change dispenser: releases the product with a timed motor pulse, then pays
// the owed change out one coin at a time through a req/ack coin hopper.
// Coins are paid largest first (2s, then a single 1). A hopper that never
// acknowledges a request locks the block in FAULT until reset.
module change_dispenser #(
    parameter int PRODUCT_CYCLES = 4,
    parameter int ACK_TIMEOUT    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d,
    input  logic [2:0] r,
    input  logic       ack,
    output logic       vend_motor,
    output logic       eject_two,
    output logic       eject_one,
    output logic       busy,
    output logic       fault,
    output logic [2:0] paid,
    output logic [2:0] cs
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        VEND  = 3'd1,
        EJECT = 3'd2,
        GAP   = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int CW = $clog2(PRODUCT_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PRODUCT_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);

    state_t        state, nxt;
    logic [2:0]    bal, bal_n, paid_n, coin;
    logic [CW-1:0] cnt, cnt_n;
    logic [TW-1:0] tmr, tmr_n;

    // The coin on offer depends only on the remaining balance, so it stays
    // constant for the whole time a request is held.
    assign coin = (bal >= 3'd2) ? 3'd2 : 3'd1;
    assign cs   = state;

    // Next-state and datapath decisions; outputs are registered from these.
    always_comb begin
        nxt    = state;
        bal_n  = bal;
        paid_n = paid;
        cnt_n  = cnt;
        tmr_n  = tmr;
        case (state)
            IDLE: begin
                if (d) begin
                    nxt    = VEND;
                    bal_n  = r;
                    paid_n = 3'd0;
                    cnt_n  = '0;
                end
            end
            VEND: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    tmr_n = '0;
                    nxt   = (bal != 3'd0) ? EJECT : IDLE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            EJECT: begin
                // An acknowledge on the timeout edge still counts as a success.
                if (ack) begin
                    bal_n  = bal - coin;
                    paid_n = paid + coin;
                    tmr_n  = '0;
                    nxt    = GAP;
                end else if (tmr == TMR_LAST) begin
                    nxt = FAULT;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            GAP: begin
                tmr_n = '0;
                nxt   = (bal != 3'd0) ? EJECT : IDLE;
            end
            FAULT: begin
                nxt = FAULT;
            end
            default: begin
                nxt = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs, all cleared by the async reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bal        <= 3'd0;
            paid       <= 3'd0;
            cnt        <= '0;
            tmr        <= '0;
            vend_motor <= 1'b0;
            eject_two  <= 1'b0;
            eject_one  <= 1'b0;
            busy       <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= nxt;
            bal        <= bal_n;
            paid       <= paid_n;
            cnt        <= cnt_n;
            tmr        <= tmr_n;
            vend_motor <= (nxt == VEND);
            eject_two  <= (nxt == EJECT) && (bal_n >= 3'd2);
            eject_one  <= (nxt == EJECT) && (bal_n <  3'd2);
            busy       <= (nxt != IDLE);
            fault      <= (nxt == FAULT);
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: reset, plain vend, multi-coin change,
// ignored requests while busy, hopper timeout and stray acknowledges.
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       d;
    logic [2:0] r;
    logic       ack;
    logic       vend_motor, eject_two, eject_one, busy, fault;
    logic [2:0] paid, cs;

    int errors = 0;
    int checks = 0;

    change_dispenser #(.PRODUCT_CYCLES(4), .ACK_TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .d          (d),
        .r          (r),
        .ack        (ack),
        .vend_motor (vend_motor),
        .eject_two  (eject_two),
        .eject_one  (eject_one),
        .busy       (busy),
        .fault      (fault),
        .paid       (paid),
        .cs         (cs)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic dv, input logic [2:0] rv, input logic av);
        d   = dv;
        r   = rv;
        ack = av;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Bounded wait for the hopper request to appear.
    task automatic waitEject(input string tag);
        int n = 0;
        while (!(eject_two || eject_one) && n < 20) begin
            tick();
            n++;
        end
        checkOutput(tag, int'(eject_two | eject_one), 1);
    endtask

    // Serve one coin: check which coin is requested, acknowledge after
    // 'delay' cycles, then check the gap cycle and running total.
    task automatic serveCoin(input string tag, input logic expTwo,
                             input int expPaid, input int delay);
        waitEject({tag, "_req"});
        checkOutput({tag, "_two"}, int'(eject_two), int'(expTwo));
        checkOutput({tag, "_one"}, int'(eject_one), int'(!expTwo));
        repeat (delay - 1) tick();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checkOutput({tag, "_gap_cs"}, int'(cs), 3);
        checkOutput({tag, "_gap_ej"}, int'(eject_two | eject_one), 0);
        checkOutput({tag, "_paid"}, int'(paid), expPaid);
    endtask

    initial begin
        int motorCnt;
        int busyCnt;
        int ejectSeen;
        int ejectCnt;
        int n;

        reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 1'b0);
        tick();
        tick();
        checkOutput("rst_cs", int'(cs), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_paid", int'(paid), 0);
        checkOutput("rst_fault", int'(fault), 0);
        checkOutput("rst_motor", int'(vend_motor), 0);
        reset = 1'b1;
        tick();

        // Async reset in the middle of a two-coin request, then a clean vend.
        applyStimulus(1'b1, 3'd5, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        serveCoin("t1_c1", 1'b1, 2, 2);
        waitEject("t1_req2");
        checkOutput("t1_pre_two", int'(eject_two), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t1_async_cs", int'(cs), 0);
        checkOutput("t1_async_two", int'(eject_two), 0);
        checkOutput("t1_async_paid", int'(paid), 0);
        checkOutput("t1_async_busy", int'(busy), 0);
        #1;
        reset = 1'b1;
        tick();
        applyStimulus(1'b1, 3'd3, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        serveCoin("t1_v1", 1'b1, 2, 2);
        serveCoin("t1_v2", 1'b0, 3, 2);
        tick();
        checkOutput("t1_end_cs", int'(cs), 0);
        checkOutput("t1_end_paid", int'(paid), 3);

        // Zero change: motor pulse only.
        applyStimulus(1'b1, 3'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        motorCnt  = 0;
        busyCnt   = 0;
        ejectSeen = 0;
        for (int i = 0; i < 10; i++) begin
            motorCnt  += int'(vend_motor);
            busyCnt   += int'(busy);
            ejectSeen += int'(eject_two | eject_one);
            tick();
        end
        checkOutput("t2_motor_cycles", motorCnt, 4);
        checkOutput("t2_busy_cycles", busyCnt, 4);
        checkOutput("t2_no_eject", ejectSeen, 0);
        checkOutput("t2_paid", int'(paid), 0);
        checkOutput("t2_cs", int'(cs), 0);

        // r=5: two, two, one.
        applyStimulus(1'b1, 3'd5, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("t3_vend_cs", int'(cs), 1);
        checkOutput("t3_motor", int'(vend_motor), 1);
        serveCoin("t3_c1", 1'b1, 2, 2);
        serveCoin("t3_c2", 1'b1, 4, 2);
        serveCoin("t3_c3", 1'b0, 5, 2);
        tick();
        checkOutput("t3_end_cs", int'(cs), 0);
        checkOutput("t3_end_busy", int'(busy), 0);
        checkOutput("t3_end_paid", int'(paid), 5);

        // r=7 with d held high while busy: must be ignored.
        applyStimulus(1'b1, 3'd7, 1'b0);
        tick();
        applyStimulus(1'b1, 3'd3, 1'b0);
        serveCoin("t4_c1", 1'b1, 2, 2);
        serveCoin("t4_c2", 1'b1, 4, 3);
        serveCoin("t4_c3", 1'b1, 6, 1);
        applyStimulus(1'b0, 3'd0, 1'b0);
        serveCoin("t4_c4", 1'b0, 7, 2);
        tick();
        checkOutput("t4_end_cs", int'(cs), 0);
        checkOutput("t4_end_paid", int'(paid), 7);
        tick();
        checkOutput("t4_no_requeue", int'(cs), 0);

        // Hopper never acknowledges: 8 cycles of request, then FAULT.
        applyStimulus(1'b1, 3'd2, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        waitEject("t5_req");
        checkOutput("t5_two", int'(eject_two), 1);
        ejectCnt = 0;
        n = 0;
        while (cs == 3'd2 && n < 20) begin
            ejectCnt++;
            n++;
            tick();
        end
        checkOutput("t5_eject_cycles", ejectCnt, 8);
        checkOutput("t5_fault", int'(fault), 1);
        checkOutput("t5_two_off", int'(eject_two), 0);
        checkOutput("t5_cs", int'(cs), 4);
        checkOutput("t5_busy", int'(busy), 1);
        applyStimulus(1'b1, 3'd1, 1'b1);
        repeat (3) tick();
        applyStimulus(1'b0, 3'd0, 1'b0);
        checkOutput("t5_sticky_cs", int'(cs), 4);
        checkOutput("t5_sticky_fault", int'(fault), 1);
        checkOutput("t5_frozen_paid", int'(paid), 0);
        checkOutput("t5_no_motor", int'(vend_motor), 0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_clear_fault", int'(fault), 0);
        checkOutput("t5_clear_cs", int'(cs), 0);
        #1;
        reset = 1'b1;
        tick();

        // r=1 with stray acknowledges in VEND, GAP and IDLE.
        applyStimulus(1'b1, 3'd1, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 1'b1);
        tick();
        ack = 1'b0;
        checkOutput("t6_vend_cs", int'(cs), 1);
        waitEject("t6_req");
        checkOutput("t6_one", int'(eject_one), 1);
        checkOutput("t6_two", int'(eject_two), 0);
        tick();
        checkOutput("t6_hold_cs", int'(cs), 2);
        checkOutput("t6_hold_paid", int'(paid), 0);
        ack = 1'b1;
        tick();
        checkOutput("t6_gap_cs", int'(cs), 3);
        checkOutput("t6_gap_paid", int'(paid), 1);
        tick();
        checkOutput("t6_idle_cs", int'(cs), 0);
        checkOutput("t6_idle_paid", int'(paid), 1);
        tick();
        ack = 1'b0;
        checkOutput("t6_idle_ack_cs", int'(cs), 0);
        checkOutput("t6_idle_ack_paid", int'(paid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
